// File: rtl/rom_arbiter.sv
// Round-robin arbiter between the fetch and data units for the shared 16-bit boot ROM.
// Misaligned word reads become two byte accesses; all ROM-side and ack/data outputs are registered.
module rom_arbiter #(
    parameter int WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [19:0] if_addr,
    input  logic        if_word,
    output logic        if_ack,
    output logic [15:0] if_data,
    input  logic        du_req,
    input  logic [19:0] du_addr,
    input  logic        du_word,
    output logic        du_ack,
    output logic [15:0] du_data,
    output logic        rom_en,
    output logic [1:0]  rom_be,
    output logic [19:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, ACK = 2'd3} state_t;

    localparam int CW = (WAIT > 1) ? $clog2(WAIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT - 1);

    state_t        state, state_next;
    logic          last, last_next;     // 0 = fetch granted last, 1 = data unit
    logic          port, port_next;     // granted requester, same encoding as last
    logic [19:0]   addr_q, addr_next;
    logic          word_q, word_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [7:0]    low_q, low_next;
    logic          rom_en_next;
    logic [1:0]    rom_be_next;
    logic [19:0]   rom_addr_next;
    logic          if_ack_next, du_ack_next;
    logic [15:0]   if_data_next, du_data_next;
    logic [15:0]   result;
    logic          done;
    logic          grant_any, grant_du, acc_done, split;

    assign grant_any = if_req | du_req;
    assign grant_du  = du_req & (~if_req | ~last);
    assign acc_done  = (cnt == CNT_LAST);
    assign split     = word_q & addr_q[0];
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any) state_next = ACC0;
            ACC0:    if (acc_done) state_next = split ? ACC1 : ACK;
            ACC1:    if (acc_done) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        last_next     = last;
        port_next     = port;
        addr_next     = addr_q;
        word_next     = word_q;
        cnt_next      = cnt;
        low_next      = low_q;
        rom_en_next   = rom_en;
        rom_be_next   = rom_be;
        rom_addr_next = rom_addr;
        if_ack_next   = 1'b0;
        du_ack_next   = 1'b0;
        if_data_next  = if_data;
        du_data_next  = du_data;
        result        = 16'h0000;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    port_next     = grant_du;
                    last_next     = grant_du;
                    addr_next     = grant_du ? du_addr : if_addr;
                    word_next     = grant_du ? du_word : if_word;
                    cnt_next      = '0;
                    rom_en_next   = 1'b1;
                    rom_addr_next = addr_next;
                    rom_be_next   = addr_next[0] ? 2'b10 : (word_next ? 2'b11 : 2'b01);
                end
            end
            ACC0: begin
                cnt_next = acc_done ? '0 : cnt + CW'(1);
                if (acc_done) begin
                    if (split) begin
                        // Odd byte now, its upper neighbour (wrapping at 2^20) in ACC1.
                        low_next      = rom_data[15:8];
                        rom_addr_next = addr_q + 20'd1;
                        rom_be_next   = 2'b01;
                    end else begin
                        done = 1'b1;
                        if (word_q)         result = rom_data;
                        else if (addr_q[0]) result = {8'h00, rom_data[15:8]};
                        else                result = {8'h00, rom_data[7:0]};
                    end
                end
            end
            ACC1: begin
                cnt_next = acc_done ? '0 : cnt + CW'(1);
                if (acc_done) begin
                    done   = 1'b1;
                    result = {rom_data[7:0], low_q};
                end
            end
            default: ;
        endcase
        if (done) begin
            rom_en_next = 1'b0;
            rom_be_next = 2'b00;
            if (port) begin
                du_ack_next  = 1'b1;
                du_data_next = result;
            end else begin
                if_ack_next  = 1'b1;
                if_data_next = result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last     <= 1'b0;
            port     <= 1'b0;
            addr_q   <= 20'h00000;
            word_q   <= 1'b0;
            cnt      <= '0;
            low_q    <= 8'h00;
            rom_en   <= 1'b0;
            rom_be   <= 2'b00;
            rom_addr <= 20'h00000;
            if_ack   <= 1'b0;
            du_ack   <= 1'b0;
            if_data  <= 16'h0000;
            du_data  <= 16'h0000;
        end else begin
            last     <= last_next;
            port     <= port_next;
            addr_q   <= addr_next;
            word_q   <= word_next;
            cnt      <= cnt_next;
            low_q    <= low_next;
            rom_en   <= rom_en_next;
            rom_be   <= rom_be_next;
            rom_addr <= rom_addr_next;
            if_ack   <= if_ack_next;
            du_ack   <= du_ack_next;
            if_data  <= if_data_next;
            du_data  <= du_data_next;
        end
    end

endmodule
